fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
Pointer/flag controller that turns one dpram instance into a synchronous single-clock FIFO. Port A of the RAM is dedicated to writes and port B to reads. The block owns the write/read pointers, occupancy count, full/empty flags and the read-valid pipeline stage matching the RAM's 1-cycle registered read. It sits between FIFO producers/consumers and the dpram instance inside the FIFO top level.

Parameters:
DATA, 16, data word width; must match the dpram DATA parameter
ADDR, 5, RAM address width; depth = 2**ADDR entries; must match the dpram ADDR parameter

Ports:
clK  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
push  input  1  write request
push_data  input  DATA  write word
full  output  1  FIFO holds 2**ADDR entries
pop  input  1  read request
pop_data  output  DATA  read word, meaningful when pop_valid=1
pop_valid  output  1  pop_data holds the word for a pop accepted last cycle
empty  output  1  FIFO holds 0 entries
count  output  ADDR+1  current occupancy, 0..2**ADDR
ram_a_WR  output  1  to dpram a_port_WR
ram_a_ADDR  output  ADDR  to dpram a_port_ADDR
ram_a_data_IN  output  DATA  to dpram a_port_data_IN
ram_b_WR  output  1  to dpram b_port_WR, constant 0
ram_b_ADDR  output  ADDR  to dpram b_port_ADDR
ram_b_data_OUT  input  DATA  from dpram b_port_data_OUT

Behaviour:
- Clock clK; reset rst is synchronous and active-high; no other clocks or resets.
- Internal wr_ptr and rd_ptr are ADDR+1 bits wide. RAM address = ptr[ADDR-1:0]. The MSB is a wrap bit; pointers wrap modulo 2**(ADDR+1).
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_valid=0, ram_a_WR=0. pop_data follows the RAM and has no reset value.
- push_acc = push & ~full. When full, push is ignored even if pop is also asserted in the same cycle.
- pop_acc = pop & ~empty. When empty, pop is ignored even if push is also asserted in the same cycle.
- Write path (combinational):
  - ram_a_WR = push_acc
  - ram_a_ADDR = wr_ptr[ADDR-1:0]
  - ram_a_data_IN = push_data
  - wr_ptr increments by 1 on push_acc.
- Read path:
  - ram_b_ADDR = rd_ptr[ADDR-1:0], combinational.
  - The RAM registers its output at the edge, so pop_valid is pop_acc registered (1-cycle latency).
  - pop_data = ram_b_data_OUT, passed straight through.
  - rd_ptr increments by 1 on pop_acc.
- count update per cycle:
  - +1 on push_acc only
  - -1 on pop_acc only
  - unchanged when both or neither occur.
- full = (count == 2**ADDR) and empty = (count == 0), both decoded from registered state only.
- Consistency invariant: count == wr_ptr - rd_ptr (mod 2**(ADDR+1)) at all times.
- Collision freedom: a same-address read/write would require empty with pop or full with push, and both are blocked. No read-during-write hazard reaches the consumer.
- Back-to-back pops are allowed: one word per cycle, and pop_valid stays high continuously.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - A pop accepted in the cycle rst is asserted does not produce pop_valid.
  - RAM contents are left unchanged but become unreachable.
- No state machine beyond the pointers and count; the block is single-cycle throughput in both directions.

Optional Feature:
Macro FIFO_CTRL_ERR_FLAGS_EN.
- Defined: adds two outputs, ovf and udf (1 bit each, reset 0).
  - ovf becomes sticky 1 the cycle after push & full.
  - udf becomes sticky 1 the cycle after pop & empty.
  - Both clear only on rst.
- Undefined: the ports and logic are absent; rejected requests are dropped silently.

Test Plan:
1. Hold rst=1 for 2 cycles with push=pop=1 -> empty=1, full=0, count=0, pop_valid=0, ram_a_WR=0 throughout.
2. Push 0x0000..0x001F on 32 consecutive cycles (ADDR=5) -> count reaches 32, full=1 on the cycle after the 32nd push. A 33rd push with value 0xBEEF leaves ram_a_WR=0 and count=32 (ovf=1 if the macro is defined).
3. From full, pop 32 consecutive cycles -> pop_valid high for 32 cycles starting 1 cycle after the first pop, pop_data = 0x0000..0x001F in order, empty=1, count=0 at the end.
4. With count=5, assert push and pop together for 10 cycles -> count stays 5, ram_a_WR=1 every cycle, and data order is preserved across the simultaneous traffic.
5. Perform 40 push/pop pairs with occupancy 1 -> both pointers pass address 31->0 and the wrap bit toggles, with no data corruption; full is never asserted.
6. On empty, assert pop and push together -> the pop is ignored (pop_valid=0 next cycle, udf=1 if enabled), the push is accepted, and count=1. Then assert rst while pop is accepted -> pop_valid=0 on the next cycle and count=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Pointer/flag controller that turns one dual-port RAM (dpram) into a
// synchronous single-clock FIFO. RAM port A is the write port, port B is the
// read port. This block owns the write/read pointers, the occupancy count,
// the full/empty flags and the read-valid stage that lines up with the RAM's
// one-cycle registered read.
//
// Parameters:
//   DATA  word width (must match the dpram DATA parameter)
//   ADDR  RAM address width, depth = 2**ADDR (must match the dpram ADDR)
//
// Ports:
//   clK             system clock, rising edge
//   rst             synchronous reset, active-high
//   push/push_data  write request and word
//   full            FIFO holds 2**ADDR entries
//   pop             read request
//   pop_data        read word, meaningful while pop_valid=1
//   pop_valid       pop_data holds the word for a pop accepted last cycle
//   empty           FIFO holds 0 entries
//   count           occupancy, 0..2**ADDR
//   ram_a_*         dpram port A (write only)
//   ram_b_*         dpram port B (read only, ram_b_WR tied low)
//   ovf/udf         sticky overflow/underflow flags, present only when the
//                   FIFO_CTRL_ERR_FLAGS_EN macro is defined
//
// Handshake: push is accepted in the cycle it is high while full=0; pop is
// accepted in the cycle it is high while empty=0. Requests made while the
// matching flag is set are dropped, whatever the other side does. An
// accepted pop delivers its word one cycle later, qualified by pop_valid.
// Nothing is accepted in a cycle where rst is high.
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int DATA = 16,
  parameter int ADDR = 5
) (
  input  logic            clK,
  input  logic            rst,
  input  logic            push,
  input  logic [DATA-1:0] push_data,
  output logic            full,
  input  logic            pop,
  output logic [DATA-1:0] pop_data,
  output logic            pop_valid,
  output logic            empty,
  output logic [ADDR:0]   count,
  output logic            ram_a_WR,
  output logic [ADDR-1:0] ram_a_ADDR,
  output logic [DATA-1:0] ram_a_data_IN,
  output logic            ram_b_WR,
  output logic [ADDR-1:0] ram_b_ADDR,
  input  logic [DATA-1:0] ram_b_data_OUT
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic            ovf,
  output logic            udf
`endif
);

  localparam logic [ADDR:0] DEPTH   = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] PTR_ONE = {{ADDR{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit above the RAM address.
  logic [ADDR:0] wr_ptr;
  logic [ADDR:0] rd_ptr;
  logic [ADDR:0] count_q;
  logic          pop_valid_q;
  logic          push_acc;
  logic          pop_acc;

  // Flags come from the registered count only, so the accept terms never
  // depend combinationally on the requests of the same cycle.
  always_comb begin
    full  = (count_q == DEPTH);
    empty = (count_q == '0);
  end

  // Gating with rst keeps the RAM write strobe low during reset even before
  // the registered state has been initialised.
  always_comb begin
    push_acc = push & ~full  & ~rst;
    pop_acc  = pop  & ~empty & ~rst;
  end

  // Write port: pure combinational pass-through of the accepted push.
  always_comb begin
    ram_a_WR      = push_acc;
    ram_a_ADDR    = wr_ptr[ADDR-1:0];
    ram_a_data_IN = push_data;
  end

  // Read port: the address is presented now, the RAM registers the word at
  // the edge, and pop_valid follows one cycle later to mark it.
  always_comb begin
    ram_b_WR   = 1'b0;
    ram_b_ADDR = rd_ptr[ADDR-1:0];
    pop_data   = ram_b_data_OUT;
    pop_valid  = pop_valid_q;
    count      = count_q;
  end

  always_ff @(posedge clK) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Simultaneous push and pop leave occupancy unchanged.
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  // Sticky error flags record any request that was refused because of a
  // flag; they clear only on reset.
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clK) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push && full) begin
        ovf_q <= 1'b1;
      end
      if (pop && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    ovf = ovf_q;
    udf = udf_q;
  end
`endif

endmodule
